// File: rtl/mem_map_pkg.sv
// Address map, region/state enums and the CPU address decoder shared by the
// memory-side bus responder and its OAM DMA engine.
package mem_map_pkg;

    typedef enum logic [2:0] {
        REG_ROM, REG_WRAM, REG_HRAM, REG_IE, REG_DMA, REG_UNMAPPED
    } region_t;

    typedef enum logic [1:0] {
        DMA_IDLE, DMA_START, DMA_XFER
    } dma_state_t;

    localparam logic [15:0] ROM_END   = 16'h7FFF;
    localparam logic [15:0] WRAM_BASE = 16'hC000;
    localparam logic [15:0] ECHO_END  = 16'hFDFF;
    localparam logic [15:0] ADDR_DMA  = 16'hFF46;
    localparam logic [15:0] HRAM_BASE = 16'hFF80;
    localparam logic [15:0] HRAM_END  = 16'hFFFE;
    localparam logic [15:0] ADDR_IE   = 16'hFFFF;

    // Echo space E000-FDFF folds onto WRAM, so both decode as REG_WRAM.
    function automatic region_t decode_region(input logic [15:0] addr);
        region_t r;
        if (addr <= ROM_END)                            r = REG_ROM;
        else if (addr >= WRAM_BASE && addr <= ECHO_END) r = REG_WRAM;
        else if (addr == ADDR_DMA)                      r = REG_DMA;
        else if (addr >= HRAM_BASE && addr <= HRAM_END) r = REG_HRAM;
        else if (addr == ADDR_IE)                       r = REG_IE;
        else                                            r = REG_UNMAPPED;
        return r;
    endfunction

endpackage

// File: rtl/mem_bus_oam_dma.sv
// OAM DMA engine: start delay, then one byte per slot from ROM/WRAM into OAM.
// Holds the FF46 register and the source page.
module oam_dma
    import mem_map_pkg::*;
#(
    parameter int DMA_LEN        = 160,
    parameter int SLOT_CLKS      = 4,
    parameter int DMA_START_CLKS = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [7:0]  i_start_val,
    input  logic [7:0]  i_rom_data,
    input  logic [7:0]  i_wram_data,
    output logic [14:0] o_src_addr,
    output logic        o_src_rd,
    output logic        o_oam_wr_en,
    output logic [7:0]  o_oam_addr,
    output logic [7:0]  o_oam_wr_data,
    output logic [7:0]  o_dma_reg,
    output logic        o_dma_active
);

    dma_state_t state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] n_q, n_d;
    logic [7:0] src_hi_q;
    logic [7:0] dma_reg_q;
    logic [7:0] src_byte;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= DMA_IDLE;
            cnt_q     <= 8'd0;
            n_q       <= 8'd0;
            src_hi_q  <= 8'd0;
            dma_reg_q <= 8'hFF;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            if (i_start) begin
                dma_reg_q <= i_start_val;
                src_hi_q  <= (i_start_val >= 8'hE0) ? i_start_val - 8'h20 : i_start_val;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        case (state_q)
            DMA_START: begin
                if (cnt_q == 8'(DMA_START_CLKS - 1)) begin
                    state_d = DMA_XFER;
                    cnt_d   = 8'd0;
                    n_d     = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DMA_XFER: begin
                if (cnt_q == 8'(SLOT_CLKS - 1)) begin
                    cnt_d = 8'd0;
                    if (n_q == 8'(DMA_LEN - 1)) begin
                        state_d = DMA_IDLE;
                        n_d     = 8'd0;
                    end else begin
                        n_d = n_q + 8'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: ;
        endcase
        // A write to FF46 in any state (re)starts from byte 0.
        if (i_start) begin
            state_d = DMA_START;
            cnt_d   = 8'd0;
            n_d     = 8'd0;
        end
    end

    // Source data arrives the clock after the slot's read strobe.
    always_comb begin
        if (src_hi_q < 8'h80)                         src_byte = i_rom_data;
        else if (src_hi_q >= 8'hC0 && src_hi_q <= 8'hDF) src_byte = i_wram_data;
        else                                          src_byte = 8'hFF;
    end

    assign o_src_rd      = (state_q == DMA_XFER) && (cnt_q == 8'd0);
    assign o_oam_wr_en   = (state_q == DMA_XFER) && (cnt_q == 8'd1);
    assign o_oam_wr_data = o_oam_wr_en ? src_byte : 8'h00;
    assign o_oam_addr    = n_q;
    assign o_src_addr    = {src_hi_q[6:0], n_q};
    assign o_dma_reg     = dma_reg_q;
    assign o_dma_active  = (state_q != DMA_IDLE);

endmodule

// File: rtl/mem_bus.sv
// Memory-side responder for the CPU bus: decode, WRAM/HRAM/IE storage,
// one-clock read mux, and OAM DMA bus blocking.
module mem_bus
    import mem_map_pkg::*;
#(
    parameter int WRAM_AW        = 13,
    parameter int DMA_LEN        = 160,
    parameter int SLOT_CLKS      = 4,
    parameter int DMA_START_CLKS = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_mem_rd_addr,
    output logic [7:0]  o_mem_rd_data,
    input  logic        i_mem_wr_en,
    input  logic [15:0] i_mem_wr_addr,
    input  logic [7:0]  i_mem_wr_data,
    output logic [14:0] o_rom_addr,
    input  logic [7:0]  i_rom_data,
    output logic        o_oam_wr_en,
    output logic [7:0]  o_oam_addr,
    output logic [7:0]  o_oam_wr_data,
    output logic        o_dma_active
);

    region_t rd_region, wr_region, reg_q;
    logic [7:0] wram [0:(1<<WRAM_AW)-1];
    logic [7:0] hram [0:126];
    logic [7:0] wram_q, hram_q, ie_q, dma_reg;
    logic [WRAM_AW-1:0] wram_raddr;
    logic [14:0] dma_src;
    logic dma_src_rd, dma_start, wram_we, hram_we, ie_we;

    assign rd_region = decode_region(i_mem_rd_addr);
    assign wr_region = decode_region(i_mem_wr_addr);

    // While DMA runs only HRAM and the FF46 restart reach the bus.
    assign dma_start = i_mem_wr_en && (wr_region == REG_DMA);
    assign hram_we   = i_mem_wr_en && (wr_region == REG_HRAM);
    assign wram_we   = i_mem_wr_en && (wr_region == REG_WRAM) && !o_dma_active;
    assign ie_we     = i_mem_wr_en && (wr_region == REG_IE) && !o_dma_active;

    assign wram_raddr = dma_src_rd ? dma_src[WRAM_AW-1:0] : i_mem_rd_addr[WRAM_AW-1:0];
    assign o_rom_addr = i_rst ? 15'd0 : (o_dma_active ? dma_src : i_mem_rd_addr[14:0]);

    always_ff @(posedge i_clk) begin
        wram_q <= wram[wram_raddr];
        if (wram_we) wram[i_mem_wr_addr[WRAM_AW-1:0]] <= i_mem_wr_data;
    end

    always_ff @(posedge i_clk) begin
        if (rd_region == REG_HRAM) hram_q <= hram[i_mem_rd_addr[6:0]];
        if (hram_we) hram[i_mem_wr_addr[6:0]] <= i_mem_wr_data;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            reg_q <= REG_UNMAPPED;
            ie_q  <= 8'h00;
        end else begin
            reg_q <= (o_dma_active && rd_region != REG_HRAM) ? REG_UNMAPPED : rd_region;
            if (ie_we) ie_q <= i_mem_wr_data;
        end
    end

    always_comb begin
        o_mem_rd_data = 8'hFF;
        case (reg_q)
            REG_ROM:  o_mem_rd_data = i_rom_data;
            REG_WRAM: o_mem_rd_data = wram_q;
            REG_HRAM: o_mem_rd_data = hram_q;
            REG_IE:   o_mem_rd_data = ie_q;
            REG_DMA:  o_mem_rd_data = dma_reg;
            default:  o_mem_rd_data = 8'hFF;
        endcase
    end

    oam_dma #(
        .DMA_LEN        (DMA_LEN),
        .SLOT_CLKS      (SLOT_CLKS),
        .DMA_START_CLKS (DMA_START_CLKS)
    ) u_dma (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_start       (dma_start),
        .i_start_val   (i_mem_wr_data),
        .i_rom_data    (i_rom_data),
        .i_wram_data   (wram_q),
        .o_src_addr    (dma_src),
        .o_src_rd      (dma_src_rd),
        .o_oam_wr_en   (o_oam_wr_en),
        .o_oam_addr    (o_oam_addr),
        .o_oam_wr_data (o_oam_wr_data),
        .o_dma_reg     (dma_reg),
        .o_dma_active  (o_dma_active)
    );

endmodule

// File: tb/tb_mem_bus.sv
// Directed bench for mem_bus: table of bus read/write vectors plus DMA,
// DMA restart and reset-mid-DMA sequences against a 1-clock ROM model.
module tb_mem_bus;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] rd_addr;
    logic [7:0]  rd_data;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic [14:0] rom_addr;
    logic [7:0]  rom_data = 8'h00;
    logic        oam_wr_en;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wr_data;
    logic        dma_active;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic        we;
        logic [15:0] wa;
        logic [7:0]  wd;
        logic [15:0] ra;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs [14];

    mem_bus dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_mem_rd_addr (rd_addr),
        .o_mem_rd_data (rd_data),
        .i_mem_wr_en   (wr_en),
        .i_mem_wr_addr (wr_addr),
        .i_mem_wr_data (wr_data),
        .o_rom_addr    (rom_addr),
        .i_rom_data    (rom_data),
        .o_oam_wr_en   (oam_wr_en),
        .o_oam_addr    (oam_addr),
        .o_oam_wr_data (oam_wr_data),
        .o_dma_active  (dma_active)
    );

    always #5 clk = ~clk;

    // Synchronous ROM whose contents are the low address byte.
    always @(posedge clk) rom_data <= rom_addr[7:0];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        int wr_cnt, act_cnt, exp_idx, phase;
        bit done, hit;

        rst = 1'b1; rd_addr = 16'h0000; wr_en = 1'b0; wr_addr = 16'h0000; wr_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_data", {8'h0, rd_data}, 16'h00FF);
        chk("rst_rom_addr", {1'b0, rom_addr}, 16'h0000);
        chk("rst_oam_wr_en", {15'h0, oam_wr_en}, 16'h0000);
        chk("rst_oam_addr", {8'h0, oam_addr}, 16'h0000);
        chk("rst_oam_data", {8'h0, oam_wr_data}, 16'h0000);
        chk("rst_dma_active", {15'h0, dma_active}, 16'h0000);
        rst = 1'b0;
        tick();

        // ---------------- table-driven bus vectors ----------------
        vecs[0]  = '{1'b0, 16'h0000, 8'h00, 16'h0150, 8'h50};  // ROM
        vecs[1]  = '{1'b1, 16'hC000, 8'h77, 16'hFF00, 8'hFF};  // unmapped IO
        vecs[2]  = '{1'b0, 16'h0000, 8'h00, 16'hC000, 8'h77};  // WRAM
        vecs[3]  = '{1'b1, 16'hC123, 8'hA5, 16'hFF00, 8'hFF};
        vecs[4]  = '{1'b0, 16'h0000, 8'h00, 16'hE123, 8'hA5};  // echo
        vecs[5]  = '{1'b0, 16'h0000, 8'h00, 16'hC123, 8'hA5};
        vecs[6]  = '{1'b1, 16'h0200, 8'h11, 16'h0200, 8'h00};  // ROM write ignored
        vecs[7]  = '{1'b1, 16'hFF90, 8'h00, 16'h8000, 8'hFF};
        vecs[8]  = '{1'b1, 16'hFF90, 8'h3C, 16'hFF90, 8'h00};  // same-edge: old data
        vecs[9]  = '{1'b0, 16'h0000, 8'h00, 16'hFF90, 8'h3C};
        vecs[10] = '{1'b1, 16'hFFFF, 8'h1F, 16'hFEA0, 8'hFF};
        vecs[11] = '{1'b0, 16'h0000, 8'h00, 16'hFFFF, 8'h1F};  // IE
        vecs[12] = '{1'b0, 16'h0000, 8'h00, 16'hFF46, 8'hFF};  // DMA reg reset
        vecs[13] = '{1'b1, 16'hA000, 8'h12, 16'hA000, 8'hFF};

        for (int i = 0; i < 14; i++) begin
            wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
            rd_addr = vecs[i].ra;
            tick();
            chk($sformatf("vec%0d_rd_data", i), {8'h0, rd_data}, {8'h0, vecs[i].exp});
            chk($sformatf("vec%0d_rom_addr", i), {1'b0, rom_addr}, {1'b0, vecs[i].ra[14:0]});
        end
        wr_en = 1'b0;
        rd_addr = 16'h0000;
        tick();

        // ---------------- DMA from WRAM ----------------
        for (int i = 0; i < 160; i++) cpu_write(16'hC000 + 16'(i), 8'(i) ^ 8'h5A);
        cpu_write(16'hFF80, 8'h99);
        wr_en = 1'b1; wr_addr = 16'hFF46; wr_data = 8'hC0;
        tick();
        wr_en = 1'b0;
        chk("dma1_active_rise", {15'h0, dma_active}, 16'h0001);
        wr_cnt = 0; act_cnt = 0;
        for (int c = 0; c < 700; c++) begin
            if (dma_active) act_cnt++;
            if (oam_wr_en) begin
                chk("dma1_oam_addr", {8'h0, oam_addr}, 16'(wr_cnt));
                chk("dma1_oam_data", {8'h0, oam_wr_data}, {8'h0, 8'(wr_cnt) ^ 8'h5A});
                wr_cnt++;
            end
            if (c == 101) chk("dma1_blocked_wram_rd", {8'h0, rd_data}, 16'h00FF);
            if (c == 102) chk("dma1_hram_rd", {8'h0, rd_data}, 16'h0099);
            if (c == 100) rd_addr = 16'hC000;
            else if (c == 101) rd_addr = 16'hFF80;
            else rd_addr = 16'h0000;
            tick();
        end
        chk("dma1_oam_writes", 16'(wr_cnt), 16'd160);
        chk("dma1_active_clks", 16'(act_cnt), 16'd644);
        chk("dma1_active_fall", {15'h0, dma_active}, 16'h0000);

        // ---------------- DMA from ROM, restarted at byte 50 ----------------
        cpu_write(16'hFF46, 8'h00);
        exp_idx = 0; phase = 0; done = 1'b0;
        for (int c = 0; c < 2000 && !done; c++) begin
            if (phase == 1 && !dma_active) begin
                done = 1'b1;
            end else begin
                if (oam_wr_en) begin
                    chk("dma2_oam_addr", {8'h0, oam_addr}, 16'(exp_idx));
                    chk("dma2_oam_data", {8'h0, oam_wr_data},
                        {8'h0, (phase == 1) ? (8'(exp_idx) ^ 8'h5A) : 8'(exp_idx)});
                    exp_idx++;
                end
                if (phase == 0 && exp_idx == 51) begin
                    cpu_write(16'hFF46, 8'hC0);
                    chk("dma2_active_held", {15'h0, dma_active}, 16'h0001);
                    phase = 1; exp_idx = 0;
                end else begin
                    tick();
                end
            end
        end
        chk("dma2_done", {15'h0, done}, 16'h0001);
        chk("dma2_oam_writes", 16'(exp_idx), 16'd160);
        rd_addr = 16'hFF46;
        tick();
        chk("dma2_ff46_read", {8'h0, rd_data}, 16'h00C0);
        rd_addr = 16'h0000;

        // ---------------- reset in the middle of a DMA ----------------
        cpu_write(16'hFF46, 8'hC0);
        hit = 1'b0;
        for (int c = 0; c < 500 && !hit; c++) begin
            if (oam_wr_en && oam_addr == 8'd20) hit = 1'b1;
            else tick();
        end
        chk("dma3_reach_byte20", {15'h0, hit}, 16'h0001);
        rst = 1'b1;
        #1;
        chk("dma3_rst_oam_wr_en", {15'h0, oam_wr_en}, 16'h0000);
        chk("dma3_rst_active", {15'h0, dma_active}, 16'h0000);
        chk("dma3_rst_oam_addr", {8'h0, oam_addr}, 16'h0000);
        tick();
        rst = 1'b0;
        wr_cnt = 0;
        for (int c = 0; c < 800; c++) begin
            if (oam_wr_en || dma_active) wr_cnt++;
            tick();
        end
        chk("dma3_no_oam_after_rst", 16'(wr_cnt), 16'd0);
        rd_addr = 16'hFF46;
        tick();
        chk("dma3_ff46_reset", {8'h0, rd_data}, 16'h00FF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus.md
Name: mem_bus

Overview:
- Memory-side responder for the CPU's flat bus: CPU read address/data, write enable/address/data.
- Decodes each CPU address to one of these targets: external cartridge ROM, internal WRAM (8 KiB), HRAM (127 B), IE register, the OAM DMA register, or unmapped space.
- Contains the OAM DMA engine, which copies 160 bytes to the external OAM port and blocks CPU access outside HRAM while it runs.

Parameters:
- WRAM_AW, 13, WRAM address width (8 KiB).
- DMA_LEN, 160, bytes copied per DMA.
- SLOT_CLKS, 4, clocks per DMA byte (one M-cycle).
- DMA_START_CLKS, 4, delay from the FF46 write to the first transfer slot.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous reset, active-high
- i_mem_rd_addr  in  16  CPU read address
- o_mem_rd_data  out  8  CPU read data
- i_mem_wr_en  in  1  CPU write strobe, one clock per write
- i_mem_wr_addr  in  16  CPU write address
- i_mem_wr_data  in  8  CPU write data
- o_rom_addr  out  15  address to external synchronous ROM
- i_rom_data  in  8  ROM data, valid one clock after o_rom_addr
- o_oam_wr_en  out  1  OAM write strobe
- o_oam_addr  out  8  OAM byte index, 0..159
- o_oam_wr_data  out  8  OAM write data
- o_dma_active  out  1  high from the FF46 write until the last OAM write

Behaviour:
- Memory map:
  - 0000-7FFF: ROM.
  - C000-DFFF: WRAM.
  - E000-FDFF: echo of WRAM; use address bits [12:0].
  - FF46: DMA register.
  - FF80-FFFE: HRAM.
  - FFFF: IE, 8 bits.
  - Everything else: reads return 8'hFF, writes are ignored.
- Read latency is exactly 1 clock. i_mem_rd_addr sampled at edge k gives valid o_mem_rd_data after edge k. The region select is registered; o_mem_rd_data is the combinational mux of (registered region, WRAM/HRAM array output, i_rom_data, IE, DMA register).
- Writes take effect at the edge where i_mem_wr_en=1.
- Read and write to the same address on the same edge: the read returns the old data.
- ROM writes (0000-7FFF) are ignored; there is no MBC in this block.
- o_rom_addr = i_mem_rd_addr[14:0] when idle; it is the DMA source address during DMA.
- Reset values:
  - o_mem_rd_data = 8'hFF (registered region = UNMAPPED).
  - o_rom_addr = 0.
  - o_oam_wr_en = 0, o_oam_addr = 0, o_oam_wr_data = 0.
  - o_dma_active = 0.
  - IE = 8'h00, DMA register = 8'hFF.
  - WRAM/HRAM contents are not reset.
- DMA FSM states are IDLE, START, XFER.
  - IDLE -> START on a CPU write to FF46 with value V. Latch V into the DMA register (readable) and as the source high byte. V >= E0 is mapped to V-20 (echo). o_dma_active rises on the next edge.
  - START: wait DMA_START_CLKS clocks, then go to XFER with byte index n=0.
  - XFER, slot of SLOT_CLKS clocks per byte n:
    - clock 0: drive source {V,n} to the ROM (V<80) or WRAM (C0<=V<=DF) read port.
    - clock 1: o_oam_wr_en=1 for one clock, with o_oam_addr=n and o_oam_wr_data = source byte.
    - Any other V: source reads as 8'hFF.
  - After n=DMA_LEN-1 has been written: go to IDLE and drop o_dma_active on the following edge. Total duration = DMA_START_CLKS + DMA_LEN*SLOT_CLKS clocks.
  - Write to FF46 during START or XFER: restart. Relatch V, return to START with n=0, and keep o_dma_active high.
- While o_dma_active=1:
  - CPU reads outside FF80-FFFE return 8'hFF.
  - CPU writes outside FF80-FFFE are dropped, except FF46, which restarts the DMA.
  - HRAM stays fully accessible.
- Reset mid-DMA: immediately go to IDLE with all outputs at their reset values. No further OAM writes.

Decomposition:
- Package mem_map_pkg holds:
  - region enum {REG_ROM, REG_WRAM, REG_HRAM, REG_IE, REG_DMA, REG_UNMAPPED};
  - address constants (WRAM_BASE, ECHO_END, HRAM_BASE, ADDR_IE, ADDR_DMA);
  - DMA state enum;
  - pure function decode_region(addr).
- One sub-module, oam_dma: FSM, slot counter and byte index. It emits the source address, source strobe, OAM write signals and o_dma_active.
- mem_bus owns the WRAM/HRAM arrays and the read mux.

Test Plan:
- Reset, then read 0150, C000 and FF00, with ROM model returning addr[7:0]: rd_data = 8'h50, then the WRAM value, then 8'hFF, each exactly 1 clock after its address.
- Write C123=8'hA5, then read E123 and C123: both return 8'hA5. Write 0200=8'h11: ROM is unchanged and o_rom_addr shows no side effect.
- Same-edge write FF90=8'h3C while reading FF90 (old value 8'h00): the same-cycle read returns 8'h00 and the next read returns 8'h3C. Write FFFF=8'h1F, then read FFFF: 8'h1F.
- Preload WRAM C000+i=i^8'h5A, write FF46=8'hC0:
  - 160 OAM writes, index 0..159, data i^8'h5A;
  - o_dma_active high for exactly 4+640 clocks;
  - a read of C000 mid-DMA returns 8'hFF;
  - a read of FF80 returns HRAM.
- Write FF46=8'h00, then at byte 50 write FF46=8'hC0: OAM index restarts at 0 with WRAM data, and read of FF46 returns 8'hC0.
- Assert i_rst at byte 20 of a DMA: o_oam_wr_en=0 and o_dma_active=0 immediately. After release, no OAM writes occur, and FF46 reads back 8'hFF.
